// File: rtl/mem_arbiter_pkg.sv
// rtl/mem_arbiter_pkg.sv - shared types for the cache-to-memory arbiter
package mem_arbiter_pkg;

    typedef logic [31:0] word_t;

    // Handshake state reported by the RAM model/controller
    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    // Arbiter control: pick a winner, then serve it until release
    typedef enum logic {
        ARB  = 1'b0,
        SERV = 1'b1
    } arb_state_t;

    localparam int DEF_CPUS     = 2;
    localparam int DEF_LOCK_MAX = 4;

endpackage

// File: rtl/mem_arbiter_rr_select.sv
// rtl/mem_arbiter_rr_select.sv - combinational round-robin picker
module rr_select #(
    parameter int N  = 2,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  i_req,
    input  logic [PW-1:0] i_ptr,
    output logic [N-1:0]  o_gnt,
    output logic          o_valid
);

    // First request at or above the pointer wins; otherwise wrap to the lowest one below it
    always_comb begin
        o_gnt   = '0;
        o_valid = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (!o_valid && i_req[i] && (PW'(i) >= i_ptr)) begin
                o_gnt[i] = 1'b1;
                o_valid  = 1'b1;
            end
        end
        for (int i = 0; i < N; i++) begin
            if (!o_valid && i_req[i] && (PW'(i) < i_ptr)) begin
                o_gnt[i] = 1'b1;
                o_valid  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - multi-core icache/dcache arbiter onto one RAM port
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int CPUS     = DEF_CPUS,
    parameter int LOCK_MAX = DEF_LOCK_MAX
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic [CPUS-1:0]  iREN,
    input  word_t [CPUS-1:0] iaddr,
    output logic [CPUS-1:0]  iwait,
    output word_t [CPUS-1:0] iload,
    input  logic [CPUS-1:0]  dREN,
    input  logic [CPUS-1:0]  dWEN,
    input  word_t [CPUS-1:0] daddr,
    input  word_t [CPUS-1:0] dstore,
    output logic [CPUS-1:0]  dwait,
    output word_t [CPUS-1:0] dload,
    output logic             ramREN,
    output logic             ramWEN,
    output word_t            ramaddr,
    output word_t            ramstore,
    input  word_t            ramload,
    input  logic [1:0]       ramstate
);

    localparam int CW = (CPUS > 1) ? $clog2(CPUS) : 1;
    localparam int AW = $clog2(LOCK_MAX + 1);

    arb_state_t      r_state, w_state_next;
    logic [CW-1:0]   r_core, w_core_next;
    logic            r_isd, w_isd_next;
    logic [CW-1:0]   r_rr_ptr, w_rr_next;
    logic [AW-1:0]   r_acc_cnt, w_acc_next;

    logic [CPUS-1:0] w_dreq;
    logic [CPUS-1:0] w_dgnt, w_igat;
    logic            w_dvalid, w_ivalid;
    logic [CW-1:0]   w_didx, w_iidx;
    logic            w_g_dren, w_g_dwen, w_g_iren, w_g_req;
    logic            w_access;
    logic            w_lock_full;
    logic [CW-1:0]   w_rr_after;

    assign w_dreq      = dREN | dWEN;
    assign w_g_dren    = dREN[r_core];
    assign w_g_dwen    = dWEN[r_core];
    assign w_g_iren    = iREN[r_core];
    assign w_g_req     = r_isd ? (w_g_dren | w_g_dwen) : w_g_iren;
    assign w_access    = (ramstate_t'(ramstate) == ACCESS);
    assign w_lock_full = (r_acc_cnt == AW'(LOCK_MAX - 1));
    assign w_rr_after  = (r_core == CW'(CPUS - 1)) ? '0 : r_core + CW'(1);

    rr_select #(.N(CPUS), .PW(CW)) u_rr_d (
        .i_req   (w_dreq),
        .i_ptr   (r_rr_ptr),
        .o_gnt   (w_dgnt),
        .o_valid (w_dvalid)
    );

    rr_select #(.N(CPUS), .PW(CW)) u_rr_i (
        .i_req   (iREN),
        .i_ptr   (r_rr_ptr),
        .o_gnt   (w_igat),
        .o_valid (w_ivalid)
    );

    // Convert the one-hot picks of both classes into core indices
    always_comb begin
        w_didx = '0;
        w_iidx = '0;
        for (int c = 0; c < CPUS; c++) begin
            if (w_dgnt[c]) w_didx = CW'(c);
            if (w_igat[c]) w_iidx = CW'(c);
        end
    end

    // Read data goes to every port; only the completing requester sees wait low
    always_comb begin
        for (int c = 0; c < CPUS; c++) begin
            iload[c] = ramload;
            dload[c] = ramload;
        end
    end

    // Next-state, grant latch, lock accounting and RAM drive
    always_comb begin
        w_state_next = r_state;
        w_core_next  = r_core;
        w_isd_next   = r_isd;
        w_rr_next    = r_rr_ptr;
        w_acc_next   = r_acc_cnt;
        iwait        = '1;
        dwait        = '1;
        ramREN       = 1'b0;
        ramWEN       = 1'b0;
        ramaddr      = '0;
        ramstore     = '0;
        case (r_state)
            ARB: begin
                if (w_dvalid) begin
                    w_core_next  = w_didx;
                    w_isd_next   = 1'b1;
                    w_state_next = SERV;
                end else if (w_ivalid) begin
                    w_core_next  = w_iidx;
                    w_isd_next   = 1'b0;
                    w_state_next = SERV;
                end
            end
            SERV: begin
                // A dropped request is not driven to RAM and cannot complete
                if (w_g_req) begin
                    if (r_isd) begin
                        ramWEN   = w_g_dwen;
                        ramREN   = w_g_dren & ~w_g_dwen;
                        ramaddr  = daddr[r_core];
                        ramstore = dstore[r_core];
                    end else begin
                        ramREN   = 1'b1;
                        ramaddr  = iaddr[r_core];
                    end
                    if (w_access) begin
                        if (r_isd) dwait[r_core] = 1'b0;
                        else       iwait[r_core] = 1'b0;
                        w_acc_next = r_acc_cnt + AW'(1);
                    end
                end
                // BUSY/FREE/ERROR simply hold the request for a retry
                if (!w_g_req || (w_access && w_lock_full)) begin
                    w_state_next = ARB;
                    w_rr_next    = w_rr_after;
                    w_acc_next   = '0;
                end
            end
            default: w_state_next = ARB;
        endcase
    end

    // Arbiter state registers; reset aborts any transfer in flight
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state   <= ARB;
            r_core    <= '0;
            r_isd     <= 1'b0;
            r_rr_ptr  <= '0;
            r_acc_cnt <= '0;
        end else begin
            r_state   <= w_state_next;
            r_core    <= w_core_next;
            r_isd     <= w_isd_next;
            r_rr_ptr  <= w_rr_next;
            r_acc_cnt <= w_acc_next;
        end
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Responder side of the cache-to-memory request interface: the memory controller that each core's icache and dcache talk to.
- Serves iREN/dREN/dWEN requests from CPUS cores against one shared RAM port.
- Arbitrates between requesters, locks a grant across multi-word block transfers (writeback then fetch), and returns per-requester wait/load signals.
- Sits between the per-core caches and the RAM model/controller.

Parameters:
- CPUS, 2, number of cores; each core has one icache and one dcache request port.
- LOCK_MAX, 4, maximum completed RAM accesses per grant before forced re-arbitration (2-word writeback + 2-word fetch).

Ports:
- CLK  in  1  clock
- nRST  in  1  reset; asynchronous, active-low
- iREN  in  CPUS  icache read request, per core
- iaddr  in  CPUS x 32  icache word address
- iwait  out  CPUS  icache wait; 0 only in the cycle the access completes
- iload  out  CPUS x 32  instruction read data
- dREN  in  CPUS  dcache read request
- dWEN  in  CPUS  dcache write request
- daddr  in  CPUS x 32  dcache word address
- dstore  in  CPUS x 32  dcache write data
- dwait  out  CPUS  dcache wait; 0 only in the cycle the access completes
- dload  out  CPUS x 32  data read data
- ramREN  out  1  RAM read enable
- ramWEN  out  1  RAM write enable
- ramaddr  out  32  RAM address
- ramstore  out  32  RAM write data
- ramload  in  32  RAM read data
- ramstate  in  2  FREE=0, BUSY=1, ACCESS=2, ERROR=3

Behaviour:
- Reset, asynchronous:
  - all iwait/dwait = 1
  - ramREN = ramWEN = 0; ramaddr = ramstore = 0
  - state = ARB, rr pointer = 0, access counter = 0
- Reset asserted mid-transfer aborts the transfer immediately; no partial completion is signalled.
- Requester encoding: id = {core, isD}. The granted id is registered.
- FSM states: ARB, SERV.
- ARB:
  - All waits = 1; RAM enables = 0.
  - If any request is pending, latch the winner and go to SERV; otherwise stay in ARB.
  - Priority: any dcache request beats any icache request.
  - Among cores of the same class: round-robin starting at the rr pointer.
- SERV:
  - RAM is driven combinationally from the granted requester.
  - Dcache: ramWEN = dWEN, ramREN = dREN & ~dWEN. dREN and dWEN both high is treated as a write.
  - Icache: ramREN = 1.
  - ramaddr and ramstore come from the granted port.
- Access completion: a cycle in SERV with ramstate == ACCESS.
  - Granted wait = 0 for that cycle only.
  - Access counter increments.
  - ramload is broadcast on every iload/dload. Consumers qualify it with their own wait.
- ramstate BUSY or FREE: wait stays 1 and requests stay driven.
- ramstate ERROR: treated as BUSY. Wait stays 1 and the request is held (retry).
- Grant lock: SERV persists while the granted requester keeps its request asserted (dREN|dWEN for dcache, iREN for icache). This covers dcache WB1→WB2→FETCH1→FETCH2 without interleaving.
- Release → ARB on the next cycle, when either:
  - the granted request deasserts; or
  - the access counter reaches LOCK_MAX (checked after a completion).
- On release: rr pointer = granted core + 1 (mod CPUS); access counter cleared.
- Latency: request first seen in ARB at cycle N → RAM driven at N+1 → earliest wait=0 at N+1 if ramstate == ACCESS.
- Each subsequent word within a lock can complete on consecutive cycles.
- Non-granted requesters always see wait = 1.
- Requests arriving while another grant is held are not lost; they are served in a later ARB.

Decomposition:
- cpu_types_pkg additions:
  - ramstate_t enum (FREE/BUSY/ACCESS/ERROR)
  - arb_state_t enum (ARB/SERV)
  - word_t (existing)
- Sub-module rr_select: combinational round-robin picker (request vector, pointer → one-hot grant + valid). Instantiated twice, for the dcache and icache classes.

Test Plan:
- Core0 iREN, iaddr=0x40, ramstate ACCESS every cycle, ramload=0xDEADBEEF → ramREN=1, ramaddr=0x40 at N+1; iwait[0]=0 that cycle; iload[0]=0xDEADBEEF.
- Core0 iREN and core1 dREN asserted in the same cycle → core1 dcache served first; core0 icache served after core1's dREN drops.
- Core0 dcache writeback (dWEN, 0x100 then 0x104, dstore 0x11/0x22) then fetch (dREN, 0x200, 0x204), with core1 dREN held throughout → core1 is never granted during the 4 accesses; core1 is granted next, and rr pointer = 1.
- Both cores hold dREN continuously → grants alternate core0/core1 every LOCK_MAX=4 completions.
- ramstate BUSY for 3 cycles, then ERROR for 2, then ACCESS → dwait stays 1 for 5 cycles with ramaddr stable; dwait = 0 exactly on the ACCESS cycle.
- nRST pulsed while in SERV mid-transfer → next cycle: all waits = 1, RAM enables = 0, state ARB; a fresh request is served normally after reset.
